custom_axi_ip_mc: RTL and testbench

CUSTOM_AXI_IP_MC -- requirements
Module: custom_axi_ip_mc

---
 rtl/custom_axi_ip_mc.sv | 166 ++++++++++++++++
 tb/tb_custom_axi_ip_mc.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_ip_mc.sv
// Purpose    : per-command accumulator (inc/dec/pass) writing into NUM_CH result channels, with sticky wrap flags.
// Latency    : accept at edge T -> done_o in cycle T+BUSY_CYCLES+1, err_o in T+1; ready_o returns one cycle after either.
// Backpressure: ready_o is high only in IDLE; start_i without ready_o is dropped (no queue). Option macro: CUSTOM_AXI_IP_MC_OVF_EN.
module custom_axi_ip_mc #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 4,
    parameter int BUSY_CYCLES = 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [CH_W-1:0]                ch_sel_i,
    input  logic [1:0]                     mode_i,
    input  logic [DATA_WIDTH-1:0]          data_i,
    input  logic                           ovf_clr_i,
    output logic                           ready_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [DATA_WIDTH-1:0]          result_o,
    output logic [CH_W-1:0]                result_ch_o,
    output logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_o,
    output logic [1:0]                     status_o,
    output logic [NUM_CH-1:0]              ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [7:0]    BUSY_M1  = 8'(BUSY_CYCLES - 1);
    // One extra bit so NUM_CH itself is representable when it is a power of two.
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    state_t                              state_q, state_d;
    logic [DATA_WIDTH-1:0]               acc_q, acc_d;
    logic [1:0]                          mode_q, mode_d;
    logic [CH_W-1:0]                     ch_q, ch_d;
    logic [7:0]                          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]               result_q, result_d;
    logic [CH_W-1:0]                     result_ch_q, result_ch_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ch_data_q, ch_data_d;
    logic                                busy_wrap;

    // Next-state, accumulator step and channel write-back.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        ch_data_d   = ch_data_q;
        busy_wrap   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((mode_i != 2'd3) && ({1'b0, ch_sel_i} < NUM_CH_L)) begin
                        acc_d   = data_i;
                        mode_d  = mode_i;
                        ch_d    = ch_sel_i;
                        cnt_d   = BUSY_M1;
                        state_d = BUSY;
                    end else begin
                        // Rejected commands touch nothing but the state.
                        state_d = ERROR;
                    end
                end
            end
            BUSY: begin
                case (mode_q)
                    2'd0: begin
                        acc_d     = acc_q + DATA_WIDTH'(1);
                        busy_wrap = &acc_q;
                    end
                    2'd1: begin
                        acc_d     = acc_q - DATA_WIDTH'(1);
                        busy_wrap = ~|acc_q;
                    end
                    default: ;
                endcase
                if (cnt_q == 8'd0) begin
                    // Write results on the last BUSY edge so they are visible during DONE.
                    state_d     = DONE;
                    result_d    = acc_d;
                    result_ch_d = ch_q;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (ch_q == CH_W'(k)) begin
                            ch_data_d[k] = acc_d;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mode_q      <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            ch_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            ch_data_q   <= ch_data_d;
        end
    end

`ifdef CUSTOM_AXI_IP_MC_OVF_EN
    logic [NUM_CH-1:0] ovf_q, ovf_d;

    // Clear first, then set, so a wrap in the same cycle as a clear survives.
    always_comb begin
        ovf_d = ovf_clr_i ? '0 : ovf_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (busy_wrap && (ch_q == CH_W'(k))) begin
                ovf_d[k] = 1'b1;
            end
        end
    end

    // Sticky per-channel wrap flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    logic unused_cfg;
    assign unused_cfg = busy_wrap ^ ovf_clr_i;
    assign ovf_o      = '0;
`endif

    assign ready_o     = (state_q == IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERROR);
    assign status_o    = state_q;
    assign result_o    = result_q;
    assign result_ch_o = result_ch_q;
    assign ch_data_o   = ch_data_q;

endmodule

// File: tb/tb_custom_axi_ip_mc.sv
module tb_custom_axi_ip_mc;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int BC  = 3;
`ifdef CUSTOM_AXI_IP_MC_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic              clk, rst;
    logic              start, ovf_clr;
    logic [1:0]        ch_sel, mode;
    logic [DW-1:0]     data;
    logic              ready, done, err;
    logic [DW-1:0]     result;
    logic [1:0]        result_ch;
    logic [NCH*DW-1:0] ch_data;
    logic [1:0]        status;
    logic [NCH-1:0]    ovf;

    logic              start1, ovf_clr1;
    logic [2:0]        ch_sel1;
    logic [1:0]        mode1;
    logic [DW-1:0]     data1;
    logic              ready1, done1, err1;
    logic [DW-1:0]     result1;
    logic [2:0]        result_ch1;
    logic [5*DW-1:0]   ch_data1;
    logic [1:0]        status1;
    logic [4:0]        ovf1;

    custom_axi_ip_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BUSY_CYCLES(BC)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ch_sel_i(ch_sel), .mode_i(mode),
        .data_i(data), .ovf_clr_i(ovf_clr), .ready_o(ready), .done_o(done), .err_o(err),
        .result_o(result), .result_ch_o(result_ch), .ch_data_o(ch_data),
        .status_o(status), .ovf_o(ovf)
    );

    custom_axi_ip_mc #(.DATA_WIDTH(DW), .NUM_CH(5), .BUSY_CYCLES(BC)) dut5 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .ch_sel_i(ch_sel1), .mode_i(mode1),
        .data_i(data1), .ovf_clr_i(ovf_clr1), .ready_o(ready1), .done_o(done1), .err_o(err1),
        .result_o(result1), .result_ch_o(result_ch1), .ch_data_o(ch_data1),
        .status_o(status1), .ovf_o(ovf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          is_err;
        logic [DW-1:0] res;
        logic [1:0]    ch;
        logic [127:0]  chd;
        logic [3:0]    ovf;
        int            cyc;
    } sb_t;

    typedef struct {
        logic [1:0]    ch;
        logic [1:0]    mode;
        logic [DW-1:0] data;
        logic          is_err;
        logic [DW-1:0] res;
        logic [3:0]    ovf;
    } vec_t;

    sb_t           sb[$];
    sb_t           e;
    logic [127:0]  ch_model;
    logic [DW-1:0] prev_res;
    logic [1:0]    prev_ch;
    logic          chk_ready_next;

    // Scoreboard: pop one expectation per done/err pulse and compare everything visible.
    always @(negedge clk) begin
        if (rst) begin
            chk_ready_next = 1'b0;
        end else begin
            if (chk_ready_next) begin
                check("ready_after_end", ready, 1'b1);
                check("pulse_one_cycle", {done, err}, 2'b00);
                chk_ready_next = 1'b0;
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {done, err}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    check("kind_done", done, !e.is_err);
                    check("kind_err", err, e.is_err);
                    check("latency_cycle", cyc, e.cyc);
                    check("result_o", result, e.res);
                    check("result_ch_o", result_ch, e.ch);
                    check("ch_data_o", ch_data, e.chd);
                    check("ovf_o", ovf, e.ovf);
                    check("ready_low_at_end", ready, 1'b0);
                    chk_ready_next = 1'b1;
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] c, input logic is_err, input logic [DW-1:0] res,
                            input logic [3:0] ov, input int t);
        sb_t s;
        if (!is_err) begin
            ch_model[c*DW +: DW] = res;
            prev_res = res;
            prev_ch  = c;
        end
        s.is_err = is_err;
        s.res    = prev_res;
        s.ch     = prev_ch;
        s.chd    = ch_model;
        s.ovf    = ov;
        s.cyc    = is_err ? t : t + BC;
        sb.push_back(s);
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge clk);
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", ready, 1'b1);
    endtask

    task automatic issue(input logic [1:0] c, input logic [1:0] m, input logic [DW-1:0] d,
                         input logic is_err, input logic [DW-1:0] res, input logic [3:0] ov);
        wait_ready();
        start = 1'b1; ch_sel = c; mode = m; data = d;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(c, is_err, res, ov, cyc);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    vec_t vt[6];
    logic [3:0] o1, o9;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, w;
        o1 = OVF_ON ? 4'b0001 : 4'b0000;
        o9 = OVF_ON ? 4'b1001 : 4'b0000;
        vt[0] = '{2'd2, 2'd0, 32'h0000_0010, 1'b0, 32'h0000_0013, 4'b0000};
        vt[1] = '{2'd0, 2'd1, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, o1};
        vt[2] = '{2'd1, 2'd2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, o1};
        vt[3] = '{2'd1, 2'd3, 32'h0000_0055, 1'b1, 32'h0000_0000, o1};
        vt[4] = '{2'd3, 2'd0, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, o9};
        vt[5] = '{2'd3, 2'd1, 32'h0000_0100, 1'b0, 32'h0000_00FD, o9};

        ch_model = '0; prev_res = '0; prev_ch = '0; chk_ready_next = 1'b0;
        start = 0; ch_sel = 0; mode = 0; data = 0; ovf_clr = 0;
        start1 = 0; ch_sel1 = 0; mode1 = 0; data1 = 0; ovf_clr1 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        // Reset state, before any clock edge.
        check("rst_status", status, 2'd0);
        check("rst_ready", ready, 1'b1);
        check("rst_done_err", {done, err}, 2'b00);
        check("rst_result", result, 32'h0);
        check("rst_result_ch", result_ch, 2'd0);
        check("rst_ch_data", ch_data, 128'h0);
        check("rst_ovf", ovf, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table of commands through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            issue(vt[i].ch, vt[i].mode, vt[i].data, vt[i].is_err, vt[i].res, vt[i].ovf);
        end
        drain();
        check("ovf_sticky", ovf, o9);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 4'h0);

        // Wrap and clear in the same cycle: the set must win.
        ovf_clr = 1'b1;
        issue(2'd0, 2'd1, 32'h0, 1'b0, 32'hFFFF_FFFD, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("ovf_set_wins", ovf, o1);
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        drain();

        // Busy collision: second start during BUSY is dropped.
        issue(2'd1, 2'd0, 32'h0000_0020, 1'b0, 32'h0000_0023, 4'h0);
        @(negedge clk);
        start = 1'b1; ch_sel = 2'd2; mode = 2'd2; data = 32'h99;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("collision_ch_data", ch_data, ch_model);
        check("collision_result", result, 32'h0000_0023);

        // Back-to-back with start held high.
        wait_ready();
        start = 1'b1; ch_sel = 2'd0; mode = 2'd0; data = 32'h0;
        @(posedge clk); #1;
        t1 = cyc;
        push_exp(2'd0, 1'b0, 32'h3, 4'h0, t1);
        ch_sel = 2'd1;
        t2 = 0; w = 0;
        while (t2 == 0 && w < 20) begin
            @(negedge clk);
            if (ready) begin
                @(posedge clk); #1;
                t2 = cyc;
                push_exp(2'd1, 1'b0, 32'h3, 4'h0, t2);
            end
            w++;
        end
        start = 1'b0;
        check("b2b_spacing", t2 - t1, 5);
        drain();
        check("b2b_ch0", ch_data[31:0], 32'h3);
        check("b2b_ch1", ch_data[63:32], 32'h3);

        // Reset in the second BUSY cycle aborts without a pulse.
        wait_ready();
        start = 1'b1; ch_sel = 2'd3; mode = 2'd0; data = 32'h40;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_status", status, 2'd0);
        check("abort_ch_data", ch_data, 128'h0);
        check("abort_ready", ready, 1'b1);
        check("abort_done", done, 1'b0);
        ch_model = '0; prev_res = '0; prev_ch = '0;
        @(negedge clk);
        rst = 1'b0;
        issue(2'd2, 2'd2, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 4'h0);
        drain();

        // NUM_CH=5: out-of-range channel rejected, channel 4 usable.
        @(negedge clk);
        start1 = 1'b1; ch_sel1 = 3'd5; mode1 = 2'd0; data1 = 32'h77;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        check("n5_err", err1, 1'b1);
        check("n5_status", status1, 2'd3);
        check("n5_ready_low", ready1, 1'b0);
        @(negedge clk);
        check("n5_err_once", err1, 1'b0);
        check("n5_ready", ready1, 1'b1);
        check("n5_ch_data", ch_data1, 160'h0);
        start1 = 1'b1; ch_sel1 = 3'd4; mode1 = 2'd0; data1 = 32'h7;
        @(posedge clk); #1;
        t1 = cyc;
        start1 = 1'b0;
        w = 0;
        @(negedge clk);
        while (!done1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("n5_latency", cyc - t1, BC);
        check("n5_result", result1, 32'hA);
        check("n5_result_ch", result_ch1, 3'd4);
        check("n5_ch4", ch_data1[159:128], 32'hA);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
